// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: IEEE 1149.1 16-state machine on TCK, IR shift and
// instruction registers, DR-chain capture/shift/update strobes and
// registered TDO.
module jtag_tap_controller #(
  parameter int                   IR_LENGTH    = 5,
  parameter logic [IR_LENGTH-1:0] IDCODE_INSTR = IR_LENGTH'(1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_jtag_TMS,
  input  logic                 io_jtag_TDI,
  output logic                 io_jtag_TDO_data,
  output logic                 io_jtag_TDO_driven,
  input  logic                 io_chainIn_data,
  output logic                 io_chainOut_capture,
  output logic                 io_chainOut_shift,
  output logic                 io_chainOut_update,
  output logic                 io_chainOut_data,
  output logic [IR_LENGTH-1:0] io_output_instruction,
  output logic                 io_output_tapIsInTestLogicReset
);

  // Standard 1149.1 state encodings.
  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  // Fixed pattern captured into the IR shift register: LSBs 2'b01.
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(1);

  logic [3:0]           state_reg;
  logic [3:0]           state_next;
  logic [IR_LENGTH-1:0] ir_shift_reg;
  logic [IR_LENGTH-1:0] instruction_reg;
  logic                 tdo_data_reg;
  logic                 tdo_driven_reg;

  // Next-state decode from the TMS sample.
  always_comb begin
    state_next = TLR;
    case (state_reg)
      TLR:     state_next = io_jtag_TMS ? TLR    : RTI;
      RTI:     state_next = io_jtag_TMS ? SEL_DR : RTI;
      SEL_DR:  state_next = io_jtag_TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = io_jtag_TMS ? EX1_DR : SH_DR;
      SH_DR:   state_next = io_jtag_TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_next = io_jtag_TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = io_jtag_TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = io_jtag_TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_next = io_jtag_TMS ? SEL_DR : RTI;
      SEL_IR:  state_next = io_jtag_TMS ? TLR    : CAP_IR;
      CAP_IR:  state_next = io_jtag_TMS ? EX1_IR : SH_IR;
      SH_IR:   state_next = io_jtag_TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_next = io_jtag_TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = io_jtag_TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = io_jtag_TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_next = io_jtag_TMS ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // TAP state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= TLR;
    else        state_reg <= state_next;
  end

  // IR shift register: capture fixed pattern, shift right with TDI into MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_shift_reg <= '0;
    end else if (state_reg == CAP_IR) begin
      ir_shift_reg <= IR_CAPTURE;
    end else if (state_reg == SH_IR) begin
      ir_shift_reg <= {io_jtag_TDI, ir_shift_reg[IR_LENGTH-1:1]};
    end
  end

  // Instruction register: IDCODE on the edge entering (or staying in) TLR,
  // shifted value on UpdIR. The two never coincide since UpdIR cannot reach TLR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction_reg <= IDCODE_INSTR;
    end else if (state_next == TLR || state_reg == TLR) begin
      instruction_reg <= IDCODE_INSTR;
    end else if (state_reg == UPD_IR) begin
      instruction_reg <= ir_shift_reg;
    end
  end

  // TDO register: one edge behind the shift state, undriven elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tdo_data_reg   <= 1'b0;
      tdo_driven_reg <= 1'b0;
    end else if (state_reg == SH_IR) begin
      tdo_data_reg   <= ir_shift_reg[0];
      tdo_driven_reg <= 1'b1;
    end else if (state_reg == SH_DR) begin
      tdo_data_reg   <= io_chainIn_data;
      tdo_driven_reg <= 1'b1;
    end else begin
      tdo_data_reg   <= 1'b0;
      tdo_driven_reg <= 1'b0;
    end
  end

  // Strobes come from the state register alone, so they are exclusive.
  assign io_chainOut_capture             = (state_reg == CAP_DR);
  assign io_chainOut_shift               = (state_reg == SH_DR);
  assign io_chainOut_update              = (state_reg == UPD_DR);
  assign io_chainOut_data                = io_jtag_TDI;
  assign io_output_instruction           = instruction_reg;
  assign io_output_tapIsInTestLogicReset = (state_reg == TLR);
  assign io_jtag_TDO_data                = tdo_data_reg;
  assign io_jtag_TDO_driven              = tdo_driven_reg;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: directed vector table for IR
// scan / DR scan / pause, hand sequences for TLR recovery and async reset,
// then a random-TMS run with property checks.
module tb_jtag_tap_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       chain_in = 1'b0;
  logic       tdo_data, tdo_driven;
  logic       cap, sh, upd, chain_out, tlr;
  logic [4:0] instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_tap_controller #(.IR_LENGTH(5), .IDCODE_INSTR(5'h01)) dut (
    .clock                           (clk),
    .reset                           (rst_n),
    .io_jtag_TMS                     (tms),
    .io_jtag_TDI                     (tdi),
    .io_jtag_TDO_data                (tdo_data),
    .io_jtag_TDO_driven              (tdo_driven),
    .io_chainIn_data                 (chain_in),
    .io_chainOut_capture             (cap),
    .io_chainOut_shift               (sh),
    .io_chainOut_update              (upd),
    .io_chainOut_data                (chain_out),
    .io_output_instruction           (instr),
    .io_output_tapIsInTestLogicReset (tlr)
  );

  typedef struct packed {
    logic       tms, tdi, ch;
    logic       cap, sh, upd, tlr, td, ten;
    logic [4:0] ins;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One TCK cycle: drive on the falling edge, sample 1 time unit after rising.
  task automatic step(input logic t, input logic d, input logic c);
    @(negedge clk);
    tms = t; tdi = d; chain_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic t, d, c, ec, es, eu, el, etd, eten, input logic [4:0] ei);
    vecs.push_back('{t, d, c, ec, es, eu, el, etd, eten, ei});
  endtask

  // From RTI, scan value v into IR and return to RTI.
  task automatic load_ir(input logic [4:0] v);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i], 0);
    step(1, 0, 0); step(0, 0, 0);
    chk("load_ir.instr", 32'(instr), 32'(v));
    $display("load_ir value=%h instr=%h", v, instr);
  endtask

  initial begin
    logic [7:0] pat;
    logic       cap_seen, sh_prev, ch_prev;
    int         ones;
    pat = 8'b0100_1101;

    // IR scan from TLR: capture 01, shift in 00010.
    add(0,0,0, 0,0,0,0, 0,0, 5'h01);
    add(1,0,0, 0,0,0,0, 0,0, 5'h01);
    add(1,0,0, 0,0,0,0, 0,0, 5'h01);
    add(0,0,0, 0,0,0,0, 0,0, 5'h01);
    add(0,0,0, 0,0,0,0, 0,0, 5'h01);
    add(0,0,0, 0,0,0,0, 1,1, 5'h01);
    add(0,1,0, 0,0,0,0, 0,1, 5'h01);
    add(0,0,0, 0,0,0,0, 0,1, 5'h01);
    add(0,0,0, 0,0,0,0, 0,1, 5'h01);
    add(1,0,0, 0,0,0,0, 0,1, 5'h01);
    add(1,0,0, 0,0,0,0, 0,0, 5'h01);
    add(0,0,0, 0,0,0,0, 0,0, 5'h02);
    // DR scan from RTI: 8 shifts plus exit bit.
    add(1,0,0, 0,0,0,0, 0,0, 5'h02);
    add(0,0,0, 1,0,0,0, 0,0, 5'h02);
    add(0,0,0, 0,1,0,0, 0,0, 5'h02);
    for (int i = 0; i < 8; i++) add(0,0,pat[i], 0,1,0,0, pat[i],1, 5'h02);
    add(1,0,1, 0,0,0,0, 1,1, 5'h02);
    add(1,0,0, 0,0,1,0, 0,0, 5'h02);
    // Pause: ShDR -> Ex1DR -> PauDR x3 -> Ex2DR -> ShDR -> update.
    add(1,0,0, 0,0,0,0, 0,0, 5'h02);
    add(0,0,0, 1,0,0,0, 0,0, 5'h02);
    add(0,0,0, 0,1,0,0, 0,0, 5'h02);
    add(1,0,1, 0,0,0,0, 1,1, 5'h02);
    add(0,0,1, 0,0,0,0, 0,0, 5'h02);
    add(0,0,1, 0,0,0,0, 0,0, 5'h02);
    add(0,0,1, 0,0,0,0, 0,0, 5'h02);
    add(1,0,0, 0,0,0,0, 0,0, 5'h02);
    add(0,0,0, 0,1,0,0, 0,0, 5'h02);
    add(1,0,0, 0,0,0,0, 0,1, 5'h02);
    add(1,0,0, 0,0,1,0, 0,0, 5'h02);
    add(0,0,0, 0,0,0,0, 0,0, 5'h02);

    // Reset state.
    #12;
    chk("reset.tlr", 32'(tlr), 1);
    chk("reset.instr", 32'(instr), 32'h01);
    chk("reset.strobes", 32'({cap, sh, upd}), 0);
    chk("reset.tdo", 32'({tdo_data, tdo_driven}), 0);
    $display("reset tlr=%0d instr=%h", tlr, instr);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].tms, vecs[i].tdi, vecs[i].ch);
      chk($sformatf("v%0d.chain_out", i), 32'(chain_out), 32'(vecs[i].tdi));
      chk($sformatf("v%0d.cap", i), 32'(cap), 32'(vecs[i].cap));
      chk($sformatf("v%0d.sh", i), 32'(sh), 32'(vecs[i].sh));
      chk($sformatf("v%0d.upd", i), 32'(upd), 32'(vecs[i].upd));
      chk($sformatf("v%0d.tlr", i), 32'(tlr), 32'(vecs[i].tlr));
      chk($sformatf("v%0d.tdo", i), 32'(tdo_data), 32'(vecs[i].td));
      chk($sformatf("v%0d.tdo_en", i), 32'(tdo_driven), 32'(vecs[i].ten));
      chk($sformatf("v%0d.instr", i), 32'(instr), 32'(vecs[i].ins));
      $display("vec %0d tms=%0d tdi=%0d ch=%0d -> cap=%0d sh=%0d upd=%0d tlr=%0d tdo=%0d/%0d ir=%h",
               i, tms, tdi, chain_in, cap, sh, upd, tlr, tdo_data, tdo_driven, instr);
    end

    // Load a non-IDCODE instruction, then recover to TLR from ShIR.
    load_ir(5'h15);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0);
      if (i == 4) chk("recover.tlr_edge4", 32'(tlr), 0);
    end
    chk("recover.tlr_edge5", 32'(tlr), 1);
    chk("recover.instr", 32'(instr), 32'h01);
    $display("recover tlr=%0d instr=%h", tlr, instr);

    // Asynchronous reset in the middle of a DR shift.
    step(0, 0, 0);
    load_ir(5'h0A);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    chk("midscan.sh", 32'(sh), 1);
    chk("midscan.tdo_en", 32'(tdo_driven), 1);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("async.tlr", 32'(tlr), 1);
    chk("async.instr", 32'(instr), 32'h01);
    chk("async.strobes", 32'({cap, sh, upd}), 0);
    chk("async.tdo", 32'({tdo_data, tdo_driven}), 0);
    $display("async_reset tlr=%0d instr=%h sh=%0d tdo_en=%0d", tlr, instr, sh, tdo_driven);
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0);
    chk("release.tlr", 32'(tlr), 0);
    // Capture after reset must still present 1 then 0 on TDO.
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0); chk("post_reset.cap_lsb", 32'(tdo_data), 1);
    step(0, 0, 0); chk("post_reset.cap_b1", 32'(tdo_data), 0);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // Random TMS run with property checks.
    cap_seen = 1'b0; ones = 0; sh_prev = sh; ch_prev = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic t, c;
      t = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      ch_prev = c;
      step(t, 1'($urandom_range(0, 1)), c);
      chk("rand.exclusive", 32'(int'(cap) + int'(sh) + int'(upd) > 1), 0);
      if (upd) begin
        chk("rand.update_after_capture", 32'(cap_seen), 1);
        cap_seen = 1'b0;
      end
      if (cap) cap_seen = 1'b1;
      ones = t ? ones + 1 : 0;
      if (ones >= 5) chk("rand.five_ones_tlr", 32'(tlr), 1);
      if (tlr) chk("rand.tlr_instr", 32'(instr), 32'h01);
      if (sh_prev) chk("rand.tdo_follows_chain", 32'({tdo_driven, tdo_data}), 32'({1'b1, ch_prev}));
      sh_prev = sh;
    end
    $display("random 10000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

JTAG TAP controller that drives the capture/shift/update control of the JTAG data-register chains, the initiating end of the chain control interface. It runs on the TCK domain, tracks the IEEE 1149.1 16-state TAP machine from TMS, and holds the instruction register. It generates mutually exclusive `capture`/`shift`/`update` strobes and serial data toward the selected data chain (bypass, IDCODE, DTM). It returns TDO from the chain's serial output.

## Interface

Parameters:
- `IR_LENGTH`, default 5: instruction register width, minimum 2.
- `IDCODE_INSTR`, default 5'h01: instruction value loaded on Test-Logic-Reset.

Ports:
- `clock`, input, 1: TCK; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low; forces the reset state immediately.
- `io_jtag_TMS`, input, 1: mode select, sampled on the rising edge.
- `io_jtag_TDI`, input, 1: serial data in.
- `io_jtag_TDO_data`, output, 1: registered serial data out.
- `io_jtag_TDO_driven`, output, 1: TDO output enable.
- `io_chainIn_data`, input, 1: serial output of the selected data chain.
- `io_chainOut_capture`, output, 1: high while in Capture-DR.
- `io_chainOut_shift`, output, 1: high while in Shift-DR.
- `io_chainOut_update`, output, 1: high while in Update-DR.
- `io_chainOut_data`, output, 1: equals `io_jtag_TDI`, combinational.
- `io_output_instruction`, output, IR_LENGTH: current instruction.
- `io_output_tapIsInTestLogicReset`, output, 1: high while the state is Test-Logic-Reset.

## Operation

- State register holds 16 states. Transitions use the sampled TMS value, written here as (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauDR / UpdDR
  - PauDR: PauDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - The IR branch (CapIR…UpdIR) mirrors the DR branch.
- From any state, five consecutive TMS=1 samples reach TLR.
- Chain strobes are decoded combinationally from the state register only, so at most one of capture/shift/update is ever high. This property is mandatory.
- IR shift register, IR_LENGTH bits:
  - CapIR: loads the value with LSBs 2'b01 and all other bits 0.
  - ShIR: shifts right; TDI enters the MSB and the LSB is the serial out.
  - Holds in all other states.
- Instruction register:
  - UpdIR: loads the IR shift register contents.
  - TLR: loads IDCODE_INSTR.
  - Holds otherwise.
- TDO register, updated on every rising edge:
  - Current state ShIR: data = IR shift LSB, driven = 1.
  - Current state ShDR: data = `io_chainIn_data`, driven = 1.
  - Any other state: data = 0, driven = 0.
- Instruction decode and DR selection are outside this block. The selected chain receives the strobes and `io_chainOut_data`.

## Timing

- Reset (low, asynchronous):
  - state = TLR, instruction = IDCODE_INSTR, IR shift = 0.
  - TDO_data = 0, TDO_driven = 0.
  - Strobes all 0; tapIsInTestLogicReset = 1.
- Strobes and tapIsInTestLogicReset change one cycle after the TMS sample that caused the transition. Each stays high exactly for the cycles the state is occupied.
- `io_chainOut_data` has zero latency. Chains sample it on the same rising edge where `shift` is high.
- TDO lags by one rising edge: the bit presented in a shift-state cycle appears on TDO in the following cycle. On exit from ShDR/ShIR, driven drops one cycle after the state leaves the shift state.
- Instruction change:
  - Visible the cycle after the UpdIR cycle.
  - TLR entry: IDCODE_INSTR is loaded on the edge that registers the TLR state and is visible in the following cycle.
- Reset asserted mid-scan: the IR shift contents are discarded and the instruction reverts to IDCODE_INSTR. No update strobe is issued.
- Reset deassertion: synchronous release is the integrator's responsibility. The first rising edge after release samples TMS normally.

## Test plan

- Reset behaviour: assert reset mid-ShDR → state TLR, instruction = 5'h01, shift = 0, TDO_driven = 0, all asynchronously before the next edge.
- TLR recovery: enter ShIR, drive TMS=1 for 5 edges → tapIsInTestLogicReset = 1 after edge 5, instruction = 5'h01.
- IR scan, from TLR:
  - Stimulus: TMS 0,1,1,0,0, then TDI bits 0,1,0,0,0 LSB-first with TMS 0,0,0,0,1, then TMS 1,0.
  - TDO shows captured 1,0,0,0,0, each one cycle late.
  - Instruction becomes 5'h02 the cycle after UpdIR.
- DR scan, from RTI:
  - Stimulus: TMS 1,0,0, then 8 cycles TMS=0, then 1,1.
  - Capture high 1 cycle, shift high 9 cycles (8 + exit bit), update high 1 cycle.
  - TDO follows chainIn_data delayed 1 cycle.
- Pause: Ex1DR→PauDR hold 3 cycles→Ex2DR→ShDR → shift low throughout the pause, resumes with no extra strobe.
- Random TMS: 10k cycles with random TDI → capture/shift/update are never two-high at once. Every update strobe is preceded by capture since the last RTI/SelDR.
